// File: rtl/snake_pkg.sv
// Heading encoding, keypad geometry and row-drive table shared by the keypad front end.
package snake_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t DIR_UP    = 2'd0;
  localparam dir_t DIR_DOWN  = 2'd1;
  localparam dir_t DIR_RIGHT = 2'd2;
  localparam dir_t DIR_LEFT  = 2'd3;

  // Key indices 0..3 equal the heading they produce, so a key index is its candidate heading.
  localparam int KEY_UP       = 0;
  localparam int KEY_DOWN     = 1;
  localparam int KEY_RIGHT    = 2;
  localparam int KEY_LEFT     = 3;
  localparam int KEY_PAUSE    = 4;
  localparam int NUM_DIR_KEYS = 4;

  // Packed tables indexed by key: {PAUSE, LEFT, RIGHT, DOWN, UP}.
  localparam logic [4:0][1:0] KEY_ROW = {2'd1, 2'd1, 2'd1, 2'd0, 2'd2};
  localparam logic [4:0][1:0] KEY_COL = {2'd1, 2'd2, 2'd0, 2'd1, 2'd1};

  // Active-low one-hot row drive, indexed by row number.
  localparam logic [3:0][3:0] ROW_DRIVE = {4'b0111, 4'b1011, 4'b1101, 4'b1110};

  // UP<->DOWN and RIGHT<->LEFT differ only in bit 0.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b01;
  endfunction

  function automatic logic multi_low(input logic [3:0] cols);
    return $countones(~cols) > 1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Per-key saturating debounce counter; emits a one-cycle press event on the released->pressed transition.
module keypad_debounce
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_sample_en,
  input  logic       i_pressed,
  output logic [3:0] o_count,
  output logic       o_state,
  output logic       o_press
);

  localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_SCANS);

  logic [3:0] r_count;
  logic       r_state;
  logic       r_press;
  logic [3:0] w_next;

  always_comb begin
    w_next = r_count;
    if (i_sample_en) begin
      if (i_pressed && (r_count != CNT_MAX)) begin
        w_next = r_count + 4'd1;
      end else if (!i_pressed && (r_count != 4'd0)) begin
        w_next = r_count - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 4'd0;
      r_state <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_count <= w_next;
      if (w_next == CNT_MAX) begin
        r_state <= 1'b1;
      end else if (w_next == 4'd0) begin
        r_state <= 1'b0;
      end
      // Only the sample that first reaches the threshold fires; held keys stay silent.
      r_press <= i_sample_en && (w_next == CNT_MAX) && !r_state;
    end
  end

  assign o_count = r_count;
  assign o_state = r_state;
  assign o_press = r_press;

endmodule

// File: rtl/keypad_direction_unit.sv
// Keypad row scanner, per-key debounce and a two-entry turn queue feeding the snake heading.
// Defining KEYPAD_PAUSE_EN adds the pause key and the paused output behaviour.
module keypad_direction_unit
  import snake_pkg::*;
#(
  parameter int SCAN_DIV       = 125000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  input  logic       step_tick,
  output logic [1:0] direction,
  output logic [1:0] pending,
  output logic       paused
);

`ifdef KEYPAD_PAUSE_EN
  localparam int NUM_KEYS = 5;
`else
  localparam int NUM_KEYS = 4;
`endif

  localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);

  logic [DW-1:0] r_dwell;
  logic [1:0]    r_row;
  logic [3:0]    r_col_s1;
  logic [3:0]    r_col_s2;
  logic          w_sample_en;
  logic          w_ghost;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dwell <= '0;
      r_row   <= 2'd0;
    end else if (r_dwell == DWELL_LAST) begin
      r_dwell <= '0;
      r_row   <= r_row + 2'd1;
    end else begin
      r_dwell <= r_dwell + DW'(1);
    end
  end

  // Columns are asynchronous to clk; the dwell is long enough for the synchronizer to settle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col_s1 <= 4'hF;
      r_col_s2 <= 4'hF;
    end else begin
      r_col_s1 <= key_col;
      r_col_s2 <= r_col_s1;
    end
  end

  assign key_row     = ROW_DRIVE[r_row];
  assign w_sample_en = (r_dwell == DWELL_LAST);
  assign w_ghost     = multi_low(r_col_s2);

  logic [NUM_KEYS-1:0]      w_key_sample;
  logic [NUM_KEYS-1:0]      w_key_raw;
  logic [NUM_KEYS-1:0]      w_key_state;
  logic [NUM_KEYS-1:0]      w_key_press;
  logic [NUM_KEYS-1:0][3:0] w_key_cnt;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    assign w_key_sample[k] = w_sample_en && (r_row == KEY_ROW[k]);
    assign w_key_raw[k]    = !r_col_s2[KEY_COL[k]] && !w_ghost;

    keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
      .clk        (clk),
      .reset      (reset),
      .i_sample_en(w_key_sample[k]),
      .i_pressed  (w_key_raw[k]),
      .o_count    (w_key_cnt[k]),
      .o_state    (w_key_state[k]),
      .o_press    (w_key_press[k])
    );
  end

  logic w_unused_dbg;
  assign w_unused_dbg = ^{w_key_cnt, w_key_state};

  logic w_paused;

`ifdef KEYPAD_PAUSE_EN
  logic r_paused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_paused <= 1'b0;
    end else if (w_key_press[KEY_PAUSE]) begin
      r_paused <= !r_paused;
    end
  end

  assign w_paused = r_paused;
`else
  assign w_paused = 1'b0;
`endif

  assign paused = w_paused;

  // At most one direction event per cycle (one row sampled at a time, ghost rule covers row 1).
  dir_t w_cand;
  logic w_evt;

  always_comb begin
    w_cand = DIR_UP;
    w_evt  = 1'b0;
    for (int k = NUM_DIR_KEYS - 1; k >= 0; k--) begin
      if (w_key_press[k]) begin
        w_cand = dir_t'(k);
        w_evt  = 1'b1;
      end
    end
  end

  dir_t       r_direction;
  dir_t       r_q0;
  dir_t       r_q1;
  logic [1:0] r_pending;

  logic       w_pop;
  logic [1:0] w_pend_pp;
  dir_t       w_q0_pp;
  dir_t       w_dir_pp;
  dir_t       w_ref;
  logic       w_accept;
  dir_t       w_q0_nxt;
  dir_t       w_q1_nxt;
  logic [1:0] w_pend_nxt;

  // Pop first, then judge the new turn against the post-pop queue.
  always_comb begin
    w_pop     = step_tick && (r_pending != 2'd0) && !w_paused;
    w_pend_pp = r_pending - {1'b0, w_pop};
    w_q0_pp   = w_pop ? r_q1 : r_q0;
    w_dir_pp  = w_pop ? r_q0 : r_direction;

    if (w_pend_pp == 2'd2) begin
      w_ref = r_q1;
    end else if (w_pend_pp == 2'd1) begin
      w_ref = w_q0_pp;
    end else begin
      w_ref = w_dir_pp;
    end

    w_accept = w_evt && !w_paused && (w_pend_pp != 2'd2) &&
               (w_cand != w_ref) && (w_cand != opposite(w_ref));

    w_q0_nxt   = w_q0_pp;
    w_q1_nxt   = r_q1;
    w_pend_nxt = w_pend_pp;
    if (w_accept) begin
      if (w_pend_pp == 2'd0) begin
        w_q0_nxt = w_cand;
      end else begin
        w_q1_nxt = w_cand;
      end
      w_pend_nxt = w_pend_pp + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_direction <= DIR_RIGHT;
      r_q0        <= DIR_UP;
      r_q1        <= DIR_UP;
      r_pending   <= 2'd0;
    end else begin
      r_direction <= w_dir_pp;
      r_q0        <= w_q0_nxt;
      r_q1        <= w_q1_nxt;
      r_pending   <= w_pend_nxt;
    end
  end

  assign direction = r_direction;
  assign pending   = r_pending;

endmodule

// File: tb/tb_keypad_direction_unit.sv
// Bench for keypad_direction_unit: keypad matrix model plus a transaction-level turn-queue model.
module tb_keypad_direction_unit;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       step_tick = 1'b0;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [1:0] direction;
  logic [1:0] pending;
  logic       paused;

  logic [3:0] held_cols [4];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: heading, FIFO of accepted turns, pause flag.
  int m_dir;
  int m_q[$];
  int m_paused;

  int key_r [4] = '{2, 0, 1, 1};
  int key_c [4] = '{1, 1, 0, 2};
  int opp   [4] = '{1, 0, 3, 2};

  keypad_direction_unit #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_col  (key_col),
    .key_row  (key_row),
    .step_tick(step_tick),
    .direction(direction),
    .pending  (pending),
    .paused   (paused)
  );

  always #10 clk = ~clk;

  // Passive matrix: a held key pulls its column low while its row is driven.
  always_comb begin
    key_col = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!key_row[r]) key_col = key_col & ~held_cols[r];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_row(input logic [3:0] v);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (key_row !== v && n < 200);
    if (key_row !== v) chk("row_timeout", {28'd0, key_row}, {28'd0, v});
  endtask

  task automatic model_reset();
    m_dir = 2;
    m_q.delete();
    m_paused = 0;
  endtask

  task automatic model_press(input int d);
    int rf;
    rf = (m_q.size() > 0) ? m_q[m_q.size() - 1] : m_dir;
    if (m_paused == 0 && d != rf && d != opp[rf] && m_q.size() < 2) m_q.push_back(d);
  endtask

  task automatic model_tick();
    if (m_paused == 0 && m_q.size() > 0) m_dir = m_q.pop_front();
  endtask

  task automatic hold_key(input int row, input int col, input int cycles);
    held_cols[row][col] = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    held_cols[row][col] = 1'b0;
    repeat (4 * SCAN_CYC) @(posedge clk);
    #1;
  endtask

  task automatic press_dir(input int d);
    hold_key(key_r[d], key_c[d], 4 * SCAN_CYC);
    model_press(d);
  endtask

  task automatic tick_op();
    @(posedge clk);
    #1 step_tick = 1'b1;
    @(posedge clk);
    #1 step_tick = 1'b0;
    model_tick();
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    chk({tag, "_dir"}, {30'd0, direction}, m_dir);
    chk({tag, "_pend"}, {30'd0, pending}, m_q.size());
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [3:0] row_seq [4];
    row_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
    for (int r = 0; r < 4; r++) held_cols[r] = 4'h0;
    model_reset();

    // Reset values and scan order
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_row", {28'd0, key_row}, 32'b1110);
    chk("rst_dir", {30'd0, direction}, 2);
    chk("rst_pend", {30'd0, pending}, 0);
    chk("rst_paused", {31'd0, paused}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("scan_row", {28'd0, key_row}, {28'd0, row_seq[i]});
    end

    // Reversal then duplicate of RIGHT
    press_dir(3);
    press_dir(2);
    @(negedge clk);
    chk("rev_pend", {30'd0, pending}, 0);
    chk("rev_dir", {30'd0, direction}, 2);

    // Single turn: UP held three scans
    hold_key(2, 1, 3 * SCAN_CYC);
    model_press(0);
    @(negedge clk);
    chk("single_pend", {30'd0, pending}, 1);
    tick_op();
    @(negedge clk);
    chk("single_dir", {30'd0, direction}, 0);
    chk("single_pend0", {30'd0, pending}, 0);

    // Queue fills at two, third turn dropped
    do_reset();
    press_dir(0);
    press_dir(3);
    press_dir(1);
    @(negedge clk);
    chk("q_pend", {30'd0, pending}, 2);
    chk("q_dir", {30'd0, direction}, 2);
    tick_op();
    check_state("q_t1");
    chk("q_t1_const", {30'd0, direction}, 0);
    tick_op();
    check_state("q_t2");
    chk("q_t2_const", {30'd0, direction}, 3);

    // DOWN press event coincident with step_tick on a full queue
    do_reset();
    press_dir(0);
    press_dir(3);
    check_state("sim_full");
    wait_row(4'b0111);
    held_cols[0][1] = 1'b1;
    wait_row(4'b1110);
    wait_row(4'b1101);
    wait_row(4'b1110);
    wait_row(4'b1101);
    step_tick = 1'b1;
    @(posedge clk);
    #1 step_tick = 1'b0;
    model_tick();
    model_press(1);
    @(negedge clk);
    chk("sim_dir", {30'd0, direction}, 0);
    chk("sim_pend", {30'd0, pending}, 2);
    held_cols[0][1] = 1'b0;
    repeat (4 * SCAN_CYC) @(posedge clk);
    tick_op();
    check_state("sim_t1");
    chk("sim_t1_const", {30'd0, direction}, 3);
    tick_op();
    check_state("sim_t2");
    chk("sim_t2_const", {30'd0, direction}, 1);

    // One-scan RIGHT glitch and a row-1 ghost: neither may queue a turn
    hold_key(1, 0, SCAN_CYC);
    check_state("glitch");
    held_cols[1] = 4'b0101;
    repeat (4 * SCAN_CYC) @(posedge clk);
    #1 held_cols[1] = 4'b0000;
    repeat (4 * SCAN_CYC) @(posedge clk);
    check_state("ghost");
    chk("ghost_pend", {30'd0, pending}, 0);

`ifdef KEYPAD_PAUSE_EN
    hold_key(1, 1, 4 * SCAN_CYC);
    m_paused = 1;
    @(negedge clk);
    chk("pause_on", {31'd0, paused}, 1);
    press_dir(2);
    tick_op();
    check_state("paused_drop");
    hold_key(1, 1, 4 * SCAN_CYC);
    m_paused = 0;
    @(negedge clk);
    chk("pause_off", {31'd0, paused}, 0);
    press_dir(2);
    check_state("unpaused");
`else
    hold_key(1, 1, 4 * SCAN_CYC);
    @(negedge clk);
    chk("pause_tied", {31'd0, paused}, 0);
    check_state("pause_key_ignored");
`endif

    // Randomized presses, ticks, glitches and ghosts against the model
    for (int i = 0; i < 40; i++) begin
      int r;
      int d;
      r = $urandom_range(0, 9);
      d = $urandom_range(0, 3);
      if (r < 6) begin
        press_dir(d);
      end else if (r < 8) begin
        tick_op();
      end else if (r == 8) begin
        hold_key(key_r[d], key_c[d], SCAN_CYC);
      end else begin
        held_cols[1] = 4'b0101;
        repeat (3 * SCAN_CYC) @(posedge clk);
        #1 held_cols[1] = 4'b0000;
        repeat (4 * SCAN_CYC) @(posedge clk);
      end
      check_state("rnd");
    end

    // Asynchronous reset in the middle of a debounce
    press_dir(0);
    held_cols[2][1] = 1'b1;
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_row", {28'd0, key_row}, 32'b1110);
    chk("arst_dir", {30'd0, direction}, 2);
    chk("arst_pend", {30'd0, pending}, 0);
    chk("arst_paused", {31'd0, paused}, 0);
    held_cols[2][1] = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    repeat (4 * SCAN_CYC) @(posedge clk);
    check_state("post_arst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
